// File: rtl/rob_pkg.sv
// Shared widths, defaults and entry layout for the reorder buffer.
package rob_pkg;
   localparam int         ROB_DEPTH   = 8;
   localparam logic [3:0] TAG_INVALID = 4'hF;
   localparam int         TAG_W       = 4;
   localparam int         REG_W       = 5;
   localparam int         OP_W        = 6;
   localparam int         DATA_W      = 32;

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic [REG_W-1:0]  rd;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] data;
   } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer: advances on inc, returns to zero on clear.
module rob_ptr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);
   logic [W-1:0] ptr_d, ptr_q;

   // Modulo wrap comes for free from the W-bit width.
   always_comb begin
      ptr_d = ptr_q;
      if (clear)
         ptr_d = '0;
      else if (inc)
         ptr_d = ptr_q + W'(1);
   end

   always_ff @(posedge clk)
      ptr_q <= ptr_d;

   assign ptr = ptr_q;
endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order CDB capture, in-order single commit.
module rob
   import rob_pkg::*;
#(
   parameter int         ROB_DEPTH   = rob_pkg::ROB_DEPTH,
   parameter logic [3:0] TAG_INVALID = rob_pkg::TAG_INVALID
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        tag_token,
   input  logic [4:0]  alloc_rd,
   input  logic [5:0]  alloc_op,
   output logic [3:0]  avail_tag,
   output logic        full,
   input  logic        cdb_valid,
   input  logic [3:0]  cdb_tag,
   input  logic [31:0] cdb_data,
   output logic        wb_en,
   output logic [3:0]  wb_tag,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [3:0]  count
);
   localparam int PTR_W = $clog2(ROB_DEPTH);

   rob_entry_t        entry_d [ROB_DEPTH];
   rob_entry_t        entry_q [ROB_DEPTH];
   rob_entry_t        head_e;
   logic [PTR_W-1:0]  head, tail, cdb_idx;
   logic [PTR_W:0]    count_d, count_q;
   logic              wb_en_d, wb_en_q;
   logic [3:0]        wb_tag_d, wb_tag_q;
   logic [4:0]        wb_rd_d, wb_rd_q;
   logic [31:0]       wb_data_d, wb_data_q;
   logic              clear, full_w, do_alloc, do_commit, cdb_hit;

   assign clear     = rst | flush;
   assign full_w    = (count_q == (PTR_W+1)'(ROB_DEPTH));
   assign head_e    = entry_q[head];
   // All three decisions look only at registered state, so same-cycle CDB never commits.
   assign do_commit = head_e.valid & head_e.ready & ~clear;
   assign do_alloc  = tag_token & ~full_w & ~clear;
   assign cdb_idx   = cdb_tag[PTR_W-1:0];
   assign cdb_hit   = cdb_valid && (int'(cdb_tag) < ROB_DEPTH) && entry_q[cdb_idx].valid;

   rob_ptr #(.W(PTR_W)) u_head (
      .clk   (clk),
      .clear (clear),
      .inc   (do_commit),
      .ptr   (head)
   );

   rob_ptr #(.W(PTR_W)) u_tail (
      .clk   (clk),
      .clear (clear),
      .inc   (do_alloc),
      .ptr   (tail)
   );

   always_comb begin
      entry_d   = entry_q;
      count_d   = count_q;
      wb_en_d   = 1'b0;
      wb_tag_d  = TAG_INVALID;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      if (flush) begin
         for (int i = 0; i < ROB_DEPTH; i++)
            entry_d[i].valid = 1'b0;
         count_d = '0;
      end else begin
         if (cdb_hit) begin
            entry_d[cdb_idx].ready = 1'b1;
            entry_d[cdb_idx].data  = cdb_data;
         end
         if (do_commit) begin
            entry_d[head].valid = 1'b0;
            wb_en_d   = 1'b1;
            wb_tag_d  = 4'(head);
            wb_rd_d   = head_e.rd;
            wb_data_d = head_e.data;
         end
         // head==tail with a valid head means full, so alloc and commit never share an entry.
         if (do_alloc)
            entry_d[tail] = '{valid: 1'b1, ready: 1'b0, rd: alloc_rd, op: alloc_op, data: '0};
         if (do_alloc && !do_commit)
            count_d = count_q + 1'b1;
         else if (!do_alloc && do_commit)
            count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROB_DEPTH; i++)
            entry_q[i] <= '0;
         count_q   <= '0;
         wb_en_q   <= 1'b0;
         wb_tag_q  <= TAG_INVALID;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         entry_q   <= entry_d;
         count_q   <= count_d;
         wb_en_q   <= wb_en_d;
         wb_tag_q  <= wb_tag_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign full      = full_w;
   assign avail_tag = full_w ? TAG_INVALID : 4'(tail);
   assign count     = 4'(count_q);
   assign wb_en     = wb_en_q;
   assign wb_tag    = wb_tag_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table, hand sequences, random vs queue model.
module tb_rob;
   localparam logic [3:0] TI = 4'hF;

   logic        clk, rst, flush, tag_token, cdb_valid;
   logic [4:0]  alloc_rd;
   logic [5:0]  alloc_op;
   logic [3:0]  avail_tag, cdb_tag, wb_tag, count;
   logic        full, wb_en;
   logic [31:0] cdb_data, wb_data;
   logic [4:0]  wb_rd;

   int tests = 0;
   int fails = 0;

   rob dut (
      .clk(clk), .rst(rst), .flush(flush), .tag_token(tag_token),
      .alloc_rd(alloc_rd), .alloc_op(alloc_op), .avail_tag(avail_tag), .full(full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .wb_en(wb_en), .wb_tag(wb_tag), .wb_rd(wb_rd), .wb_data(wb_data), .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit rst, fl, tok; logic [4:0] rd; bit cv; logic [3:0] ctag; logic [31:0] cd;
      logic [3:0] e_av; bit e_full; logic [3:0] e_cnt; bit e_wb; logic [3:0] e_tag;
      logic [4:0] e_rd; logic [31:0] e_dat;
   } vec_t;
   vec_t tbl[$];

   task automatic add(bit r, bit f, bit t, logic [4:0] rd, bit cv, logic [3:0] ct, logic [31:0] cd,
                      logic [3:0] av, bit fu, logic [3:0] cn, bit wb, logic [3:0] tg,
                      logic [4:0] wrd, logic [31:0] wd);
      vec_t v;
      v.rst = r; v.fl = f; v.tok = t; v.rd = rd; v.cv = cv; v.ctag = ct; v.cd = cd;
      v.e_av = av; v.e_full = fu; v.e_cnt = cn; v.e_wb = wb; v.e_tag = tg; v.e_rd = wrd; v.e_dat = wd;
      tbl.push_back(v);
   endtask

   task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic check_out(int idx, logic [3:0] av, bit fu, logic [3:0] cn, bit wb,
                            logic [3:0] tg, logic [4:0] wrd, logic [31:0] wd);
      chk("avail_tag", idx, 32'(avail_tag), 32'(av));
      chk("full",      idx, 32'(full),      32'(fu));
      chk("count",     idx, 32'(count),     32'(cn));
      chk("wb_en",     idx, 32'(wb_en),     32'(wb));
      chk("wb_tag",    idx, 32'(wb_tag),    32'(tg));
      chk("wb_rd",     idx, 32'(wb_rd),     32'(wrd));
      chk("wb_data",   idx, wb_data,        wd);
   endtask

   // Inputs change 1 time unit after the edge, outputs are sampled 1 unit after the next edge.
   task automatic step(bit r, bit f, bit t, logic [4:0] rd, bit cv, logic [3:0] ct, logic [31:0] cd);
      rst = r; flush = f; tag_token = t; alloc_rd = rd; alloc_op = 6'(rd) ^ 6'h2A;
      cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
      @(posedge clk);
      #1;
   endtask

   // Reference model: program-order queue of in-flight instructions.
   typedef struct { logic [4:0] rd; bit rdy; logic [31:0] data; } ment_t;
   ment_t       mq[$];
   int          mhead;
   bit          m_wb;
   logic [3:0]  m_tag;
   logic [4:0]  m_rd;
   logic [31:0] m_dat;

   task automatic model_step(bit r, bit f, bit t, logic [4:0] rd, bit cv, logic [3:0] ct, logic [31:0] cd);
      ment_t h;
      bit    commit, alloc;
      int    pos;
      if (r) begin
         mq.delete(); mhead = 0; m_wb = 0; m_tag = TI; m_rd = 0; m_dat = 0;
      end else if (f) begin
         mq.delete(); mhead = 0; m_wb = 0; m_tag = TI;
      end else begin
         commit = (mq.size() > 0) && mq[0].rdy;
         if (commit) h = mq[0];
         alloc = t && (mq.size() < 8);
         if (cv && ct < 8) begin
            pos = (int'(ct) - mhead + 8) % 8;
            if (pos < mq.size()) begin
               mq[pos].rdy = 1; mq[pos].data = cd;
            end
         end
         if (commit) begin
            m_wb = 1; m_tag = 4'(mhead); m_rd = h.rd; m_dat = h.data;
            void'(mq.pop_front());
            mhead = (mhead + 1) % 8;
         end else begin
            m_wb = 0; m_tag = TI;
         end
         if (alloc) begin
            h.rd = rd; h.rdy = 0; h.data = 0;
            mq.push_back(h);
         end
      end
   endtask

   initial begin
      bit r, f, t, cv;
      logic [4:0]  rd;
      logic [3:0]  ct;
      logic [31:0] cd;
      int          u;

      rst = 1; flush = 0; tag_token = 0; alloc_rd = 0; alloc_op = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
      #1;

      // Fill to full, refused allocs, wrap, stray CDB, out-of-order completion, rd=0, alloc+commit.
      add(1,0,0,0,  0,0,0,        4'h0,0,0,0,TI,0,0);
      for (int k = 1; k <= 8; k++)
         add(0,0,1,5'(k),0,0,0,   (k < 8) ? 4'(k) : TI, (k == 8), 4'(k), 0, TI, 0, 0);
      add(0,0,1,9,  0,0,0,        TI,1,8,0,TI,0,0);
      add(0,0,1,10, 1,0,32'hA0,   TI,1,8,0,TI,0,0);
      add(0,0,0,0,  0,0,0,        4'h0,0,7,1,4'h0,1,32'hA0);
      add(0,0,1,11, 0,0,0,        TI,1,8,0,TI,1,32'hA0);
      add(0,0,0,0,  1,TI,32'hDEAD,TI,1,8,0,TI,1,32'hA0);
      add(0,1,0,0,  0,0,0,        4'h0,0,0,0,TI,1,32'hA0);
      add(0,0,1,5,  0,0,0,        4'h1,0,1,0,TI,1,32'hA0);
      add(0,0,1,6,  0,0,0,        4'h2,0,2,0,TI,1,32'hA0);
      add(0,0,1,7,  0,0,0,        4'h3,0,3,0,TI,1,32'hA0);
      add(0,0,0,0,  1,2,32'h22,   4'h3,0,3,0,TI,1,32'hA0);
      add(0,0,0,0,  1,0,32'h11,   4'h3,0,3,0,TI,1,32'hA0);
      add(0,0,0,0,  0,0,0,        4'h3,0,2,1,4'h0,5,32'h11);
      add(0,0,0,0,  0,0,0,        4'h3,0,2,0,TI,5,32'h11);
      add(0,0,0,0,  1,1,32'h33,   4'h3,0,2,0,TI,5,32'h11);
      add(0,0,0,0,  0,0,0,        4'h3,0,1,1,4'h1,6,32'h33);
      add(0,0,0,0,  0,0,0,        4'h3,0,0,1,4'h2,7,32'h22);
      add(0,0,0,0,  0,0,0,        4'h3,0,0,0,TI,7,32'h22);
      add(0,0,0,0,  1,1,32'h99,   4'h3,0,0,0,TI,7,32'h22);
      add(0,0,0,0,  1,0,32'h77,   4'h3,0,0,0,TI,7,32'h22);
      add(0,0,1,0,  0,0,0,        4'h4,0,1,0,TI,7,32'h22);
      add(0,0,0,0,  1,3,32'h44,   4'h4,0,1,0,TI,7,32'h22);
      add(0,0,0,0,  0,0,0,        4'h4,0,0,1,4'h3,0,32'h44);
      add(0,0,1,2,  0,0,0,        4'h5,0,1,0,TI,0,32'h44);
      add(0,0,0,0,  1,4,32'h55,   4'h5,0,1,0,TI,0,32'h44);
      add(0,0,1,3,  0,0,0,        4'h6,0,1,1,4'h4,2,32'h55);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].fl, tbl[i].tok, tbl[i].rd, tbl[i].cv, tbl[i].ctag, tbl[i].cd);
         check_out(i, tbl[i].e_av, tbl[i].e_full, tbl[i].e_cnt, tbl[i].e_wb,
                   tbl[i].e_tag, tbl[i].e_rd, tbl[i].e_dat);
      end

      // Entries 3..5 in flight, then flush together with alloc and a CDB to tag 3.
      step(1,0,0,0,0,0,0);
      step(0,0,1,1,0,0,0);
      step(0,0,1,2,0,0,0);
      step(0,0,1,3,0,0,0);
      step(0,0,0,0,1,0,32'h100);
      step(0,0,0,0,1,1,32'h101);
      step(0,0,0,0,1,2,32'h102);
      step(0,0,0,0,0,0,0);
      step(0,0,1,4,0,0,0);
      step(0,0,1,5,0,0,0);
      step(0,0,1,6,0,0,0);
      check_out(100, 4'h6,0,3,0,TI,3,32'h102);
      step(0,1,1,9,1,3,32'h333);
      check_out(101, 4'h0,0,0,0,TI,3,32'h102);
      step(0,0,0,0,0,0,0);
      check_out(102, 4'h0,0,0,0,TI,3,32'h102);

      // Reset exactly at the edge where four ready entries would start committing.
      step(1,0,0,0,0,0,0);
      for (int k = 0; k < 4; k++)
         step(0,0,1,5'(k + 4),0,0,0);
      step(0,0,0,0,1,3,32'h3);
      step(0,0,0,0,1,2,32'h2);
      step(0,0,0,0,1,1,32'h1);
      step(0,0,0,0,1,0,32'h0);
      step(1,0,0,0,0,0,0);
      check_out(200, 4'h0,0,0,0,TI,0,0);
      step(0,0,0,0,0,0,0);
      check_out(201, 4'h0,0,0,0,TI,0,0);

      // Randomized traffic against the queue model.
      step(1,0,0,0,0,0,0);
      model_step(1,0,0,0,0,0,0);
      for (int n = 0; n < 3000; n++) begin
         u  = int'($urandom_range(0, 199));
         r  = (u < 2);
         f  = (u >= 2 && u < 6);
         t  = ($urandom_range(0, 99) < 55);
         rd = 5'($urandom);
         cv = ($urandom_range(0, 1) == 1);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            ct = 4'((mhead + int'($urandom_range(0, mq.size() - 1))) % 8);
         else
            ct = 4'($urandom_range(0, 15));
         cd = $urandom;
         step(r, f, t, rd, cv, ct, cd);
         model_step(r, f, t, rd, cv, ct, cd);
         check_out(1000 + n, (mq.size() == 8) ? TI : 4'((mhead + mq.size()) % 8),
                   (mq.size() == 8), 4'(mq.size()), m_wb, m_tag, m_rd, m_dat);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
